// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// -----------------------------------------------------------------------------
// Execute-stage ALU. Add, sub, and, or and signed set-less-than complete in a
// single cycle. Logical/arithmetic shifts run iteratively, one bit position
// per clock, under a three-state controller (IDLE / BUSY / HOLD). Valid/ready
// handshakes on the operand side and the result side let the stall logic
// throttle the unit. A consumed result and a new accept may share one edge,
// so single-cycle ops stream at one per clock.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operands and alu_cntrl are valid
//   in_ready   out  1      unit accepts an operation this cycle
//   alu_cntrl  in   3      operation code
//   src_a      in   WIDTH  operand A (value shifted by shift ops)
//   src_b      in   WIDTH  operand B ([SHW-1:0] is the shift amount)
//   out_valid  out  1      result/zero are valid
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  registered result
//   zero       out  1      registered (result == 0)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // True for the three codes that are executed by the iterative shifter.
  function automatic logic is_shift(input logic [2:0] code);
    logic r;
    case (code)
      OP_SLL:  r = 1'b1;
      OP_SRL:  r = 1'b1;
      OP_SRA:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Result of every op that finishes in the accept cycle. Shift codes only
  // reach this path with a zero shift amount, where the answer is src_a.
  function automatic logic [WIDTH-1:0] single_cycle_result(
    input logic [2:0]       code,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (code)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      OP_SLL:  r = a;
      OP_SRL:  r = a;
      OP_SRA:  r = a;
      default: r = ZERO_W;
    endcase
    return r;
  endfunction

  // One-bit shift step in the direction selected by the latched op code.
  function automatic logic [WIDTH-1:0] shift_one(
    input logic [2:0]       code,
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    case (code)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] next_shreg_s;
  logic [SHW-1:0]   cnt_r;
  logic [SHW-1:0]   next_cnt_s;
  logic [2:0]       op_r;
  logic [2:0]       next_op_s;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] next_result_s;
  logic             zero_r;
  logic             load_result_s;
  logic             out_valid_r;
  logic             in_ready_s;
  logic             accept_s;
  logic [SHW-1:0]   shamt_s;

  assign shamt_s  = src_b[SHW-1:0];
  assign accept_s = in_valid & in_ready_s;

  // Ready depends only on state and out_ready: HOLD frees the slot exactly
  // when the consumer takes the pending result.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_BUSY: in_ready_s = 1'b0;
      ST_HOLD: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Next-state and datapath selection for the controller.
  always_comb begin
    next_state_s  = state_r;
    next_shreg_s  = shreg_r;
    next_cnt_s    = cnt_r;
    next_op_s     = op_r;
    next_result_s = result_r;
    load_result_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (accept_s) begin
          // IDLE and HOLD share the accept path, which is what lets a
          // consume and a new accept happen on the same edge.
          if (is_shift(alu_cntrl) && (shamt_s != CNT_ZERO)) begin
            next_state_s = ST_BUSY;
            next_shreg_s = src_a;
            next_cnt_s   = shamt_s;
            next_op_s    = alu_cntrl;
          end else begin
            next_state_s  = ST_HOLD;
            next_result_s = single_cycle_result(alu_cntrl, src_a, src_b);
            load_result_s = 1'b1;
          end
        end else if ((state_r == ST_HOLD) && out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_BUSY: begin
        next_shreg_s = shift_one(op_r, shreg_r);
        next_cnt_s   = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          // Last step: publish the final shifted value directly.
          next_state_s  = ST_HOLD;
          next_result_s = shift_one(op_r, shreg_r);
          load_result_s = 1'b1;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Controller state, shifter and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      shreg_r <= ZERO_W;
      cnt_r   <= CNT_ZERO;
      op_r    <= 3'b000;
    end else begin
      state_r <= next_state_s;
      shreg_r <= next_shreg_s;
      cnt_r   <= next_cnt_s;
      op_r    <= next_op_s;
    end
  end

  // Output registers; zero is only refreshed together with result so the
  // pair always agrees while out_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r    <= ZERO_W;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (next_state_s == ST_HOLD);
      if (load_result_s) begin
        result_r <= next_result_s;
        zero_r   <= (next_result_s == ZERO_W);
      end else begin
        result_r <= result_r;
        zero_r   <= zero_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU of the pipelined core: consumes the 3-bit `alu_cntrl` code produced by ALU control decoding, together with two operands, and returns a registered result and zero flag. Arithmetic and logic ops complete in one cycle. Shifts run iteratively, one bit per cycle, under a small state machine. Valid/ready handshakes on both sides let the hazard/stall logic throttle the unit.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two, at least 4.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived, never overridden.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and `alu_cntrl` are valid.
- `in_ready`  out  1  unit accepts an operation this cycle.
- `alu_cntrl`  in  3  operation code.
- `src_a`  in  WIDTH  operand A; the value shifted by shift ops.
- `src_b`  in  WIDTH  operand B; bits [SHW-1:0] give the shift amount.
- `out_valid`  out  1  `result` and `zero` are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered flag, equal to (result == 0).

Clock and reset are fixed: one clock, `clk`, and an asynchronous active-high reset, `rst`.

## Operation
- **Codes**
  - 000: add, modulo 2^WIDTH.
  - 001: sub, a−b modulo 2^WIDTH.
  - 010: and.
  - 011: or.
  - 101: slt, signed; result is 1 if $signed(a) < $signed(b), else 0.
  - 100: sll.
  - 110: srl.
  - 111: sra, arithmetic, replicating a[WIDTH-1].
- **Accept:** an operation is accepted when `in_valid && in_ready` at a rising edge. Operands and code are captured on that edge and are ignored at all other times.
- **State machine:**
  - IDLE: `in_ready`=1, `out_valid`=0.
  - BUSY: iterative shift in progress; `in_ready`=0, `out_valid`=0.
  - HOLD: `out_valid`=1; `in_ready` = `out_ready`.
- **Transitions:**
  - IDLE, accept of a non-shift op, or a shift with shamt=0: result computed and registered, go to HOLD. For shamt=0, result = src_a.
  - IDLE, accept of a shift with shamt>0: load the shift register with src_a and the counter with shamt, go to BUSY.
  - BUSY: each cycle shift by one bit in the coded direction and decrement the counter. When the counter goes from 1 to 0, go to HOLD.
  - HOLD, `out_ready`=0: stay in HOLD. `result` and `zero` are held stable.
  - HOLD, `out_ready`=1, no accept: go to IDLE.
  - HOLD, `out_ready`=1 and `in_valid`=1: the result is consumed and the new op is accepted on the same edge. The next state follows the IDLE rules for the new op, giving back-to-back throughput.
- `zero` is registered together with `result` and always matches it while `out_valid`=1.
- **Reset,** asserted at any time including mid-BUSY:
  - state → IDLE;
  - `out_valid`=0, `result`=0, `zero`=0, counter=0;
  - any in-flight operation is discarded.
  - `in_ready`=1 from the first cycle after `rst` deasserts.

## Timing
- Non-shift ops and shamt=0 shifts: accept at edge N, `out_valid` high after edge N (latency 1).
- Shifts with shamt=k>0: accept at edge N, `out_valid` high after edge N+k (latency k+1). The worst case is WIDTH cycles.
- Sustained throughput with `out_ready` held high is one single-cycle op per clock.
- `in_ready` is combinational from state and `out_ready` only. There is no path from `in_valid` to `in_ready`.
- `out_valid`, `result` and `zero` come directly from registers.

## Test plan
- **Add wrap:** add a=0xFFFF_FFFF, b=1 → one cycle later `out_valid`=1, result=0, zero=1. Then sub a=5, b=7 → result=0xFFFF_FFFE, zero=0.
- **Signed slt:** slt a=0xFFFF_FFFF (−1), b=1 → result=1. Then a=1, b=0xFFFF_FFFF → result=0.
- **Shift latency:**
  - sra a=0x8000_0000, b=31 → `out_valid` exactly 32 cycles after accept, result=0xFFFF_FFFF, `in_ready`=0 throughout BUSY.
  - srl with the same operands → result=1.
- **Zero shift:** sll a=0x1234, b=0x20 (shamt=0) → latency 1, result=0x1234.
- **Backpressure and back-to-back:**
  - `out_ready`=0 for 5 cycles after an and op → result and zero held constant, `in_ready`=0.
  - Raise `out_ready` with `in_valid`=1 carrying or a=0xF0, b=0x0F → first result consumed, new result 0xFF appears on the next cycle with no IDLE bubble.
- **Reset mid-shift:** assert `rst` asynchronously 3 cycles into a shamt=10 sll → outputs go to 0 immediately. After release, `in_ready`=1, `out_valid` stays 0, and a following add 2+3 returns 5.
